// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown-timer key front end.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_e;

    localparam int NUM_KEYS  = 2;
    localparam int KEY_START = 0;
    localparam int KEY_CLEAR = 1;

endpackage

// File: rtl/timer_key_ctrl_if.sv
// Button inputs, time-up feedback and timer control outputs of the key controller.
interface timer_key_ctrl_if;
    import timer_pkg::*;

    logic [NUM_KEYS-1:0] key_n;
    logic                timeup;
    logic                count_en;
    logic                clear;
    timer_state_e        state;
    logic                alarm_led;

    modport master (
        output key_n, timeup,
        input  count_en, clear, state, alarm_led
    );

    modport slave (
        input  key_n, timeup,
        output count_en, clear, state, alarm_led
    );

endinterface

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, stability filter and registered press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       sync_reg;
    logic [1:0]       fill_reg;
    logic             armed_reg;
    logic             stable_reg;
    logic             stable_d_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press_reg;
    logic             synced;

    assign synced = sync_reg[1];
    assign press  = press_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg     <= 2'b11;
            fill_reg     <= 2'b00;
            armed_reg    <= 1'b0;
            stable_reg   <= 1'b1;
            stable_d_reg <= 1'b1;
            cnt_reg      <= '0;
            press_reg    <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[0], key_n};
            fill_reg     <= {fill_reg[0], 1'b1};
            stable_d_reg <= stable_reg;
            // A key already held when reset releases must be let go once before it can count as a press.
            if (fill_reg[1] && synced)
                armed_reg <= 1'b1;
            press_reg <= armed_reg & stable_d_reg & ~stable_reg;

            if (synced == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                stable_reg <= synced;
                cnt_reg    <= '0;
            end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_key_ctrl.sv
// Mode FSM (idle/run/pause/done) driven by debounced keys and time-up, plus alarm blink.
module timer_key_ctrl
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int BLINK_CYCLES    = 2500
) (
    input  logic             clk,
    input  logic             rst_n,
    timer_key_ctrl_if.slave  bus
);
    localparam int               BLINK_W    = $clog2(BLINK_CYCLES + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [NUM_KEYS-1:0] press;
    timer_state_e        state_reg, state_next;
    logic                clear_next;
    logic                count_en_reg, clear_reg, alarm_reg;
    logic [BLINK_W-1:0]  blink_cnt_reg;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk   (clk),
                .rst_n (rst_n),
                .key_n (bus.key_n[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    // Priority: clear key, then time-up while running, then start key.
    always_comb begin
        state_next = state_reg;
        clear_next = 1'b0;
        if (press[KEY_CLEAR]) begin
            state_next = IDLE;
            clear_next = 1'b1;
        end else if (state_reg == RUN && bus.timeup) begin
            state_next = DONE;
        end else if (press[KEY_START]) begin
            case (state_reg)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                DONE: begin
                    state_next = IDLE;
                    clear_next = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_en_reg  <= 1'b0;
            clear_reg     <= 1'b0;
            alarm_reg     <= 1'b0;
            blink_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            count_en_reg <= (state_next == RUN);
            clear_reg    <= clear_next;
            if (state_next != DONE) begin
                alarm_reg     <= 1'b0;
                blink_cnt_reg <= '0;
            end else if (state_reg != DONE) begin
                alarm_reg     <= 1'b1;
                blink_cnt_reg <= '0;
            end else if (blink_cnt_reg == BLINK_LAST) begin
                alarm_reg     <= ~alarm_reg;
                blink_cnt_reg <= '0;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.state     = state_reg;
    assign bus.count_en  = count_en_reg;
    assign bus.clear     = clear_reg;
    assign bus.alarm_led = alarm_reg;

endmodule

// File: doc/timer_key_ctrl.md
# timer_key_ctrl

Front-end control for the countdown timer: synchronises and debounces the two active-low push-buttons and runs the timer's mode FSM (idle / run / pause / done). Sits directly upstream of the 1 s tick counter and digit-decoder chain. `count_en` gates the 1 s tick, and `clear` zeroes the tick counter and all digits. Also consumes `timeup` back from the counter and drives the alarm LED.

## Interface
- `DEBOUNCE_CYCLES`, default 200: consecutive stable cycles required to accept a key change (20 ms at 10 kHz).
- `BLINK_CYCLES`, default 2500: half-period of the alarm LED blink in DONE (0.25 s at 10 kHz).
- `clk`, in, 1: timer clock (10 kHz PLL output). One clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `key_n`, in, 2: raw buttons, asynchronous, active-low. `[0]` = start/pause, `[1]` = clear.
- `timeup`, in, 1: level from the counter, high while elapsed time equals the target.
- `count_en`, out, 1: high while in RUN. The downstream counter advances only when this is high.
- `clear`, out, 1: one-cycle pulse that resets the tick counter and digits.
- `state`, out, 2: current FSM state (`timer_state_e`).
- `alarm_led`, out, 1: blinks while in DONE, low otherwise.

## Operation
- **Synchroniser.** Each `key_n` bit passes through a 2-flop synchroniser. The flops reset to 1 (released).
- **Debounce (per key).**
  - Holds a `stable` value (reset 1) and a counter (reset 0).
  - Any cycle where the synced value equals `stable` clears the counter.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`-1 while still differing, `stable` flips and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. It saturates and never wraps.
- **Press event.** A one-cycle registered pulse on each 1→0 transition of `stable`. Releases (0→1) generate no event.
- **FSM states:** IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
- **FSM transitions, in priority order:**
  1. A clear press in any state → IDLE, with `clear` pulsed.
  2. In RUN with `timeup` high → DONE.
  3. A start press:
     - IDLE → RUN
     - RUN → PAUSE
     - PAUSE → RUN
     - DONE → IDLE, with `clear` pulsed.
  4. Otherwise, hold the current state.
- **`timeup` sampling.** `timeup` is sampled only in RUN. It is ignored in IDLE, PAUSE and DONE.
- **Simultaneous events.**
  - Clear and start pressed in the same cycle: clear wins and start is discarded.
  - `timeup` and start in RUN in the same cycle: DONE wins and start is discarded.
- **`count_en`.** Registered. Equals (next state == RUN), so it is valid in the same cycle the state register shows RUN.
- **Alarm LED.**
  - The blink counter runs only in DONE and is cleared to 0 in every other state.
  - `alarm_led` toggles each time the counter reaches `BLINK_CYCLES`-1.
  - On DONE entry, `alarm_led` = 1. It is forced to 0 outside DONE.
- **Reset values.** `count_en`=0, `clear`=0, `state`=IDLE, `alarm_led`=0. Asserting `rst_n` mid-operation returns everything to these values immediately, with no `clear` pulse.

## Timing
- **Key latency.** From a clean `key_n` falling edge to the state / `count_en` / `clear` update: 2 cycles (synchroniser) + `DEBOUNCE_CYCLES` cycles (filter) + 1 cycle (press register) + 1 cycle (FSM register).
  - Total = `DEBOUNCE_CYCLES`+4, with +1 uncertainty from the asynchronous arrival of the edge.
- **Bounce rejection.** A glitch or bounce shorter than `DEBOUNCE_CYCLES` synced cycles produces no event.
- **Held key.** A key held indefinitely produces exactly one event.
- **`timeup` response.** `timeup` rising in RUN → state DONE and `count_en`=0 on the next edge (1-cycle latency).
- **`clear` pulse.** Exactly 1 cycle wide. It coincides with the first cycle of `state`=IDLE.

## Structure
- **Package `timer_pkg`.**
  - Holds `typedef enum logic [1:0] timer_state_e {IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3}`.
  - Shared with the top level and with the bench.
- **Sub-module `key_debounce`.**
  - Contains the synchroniser, the filter and the falling-edge pulse. Parameter `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `rst_n`, `key_n`, `press`.
  - Instantiated twice in a generate loop.
- **Top-level integration.**
  - `timer_key_ctrl` holds the FSM, the blink counter and the output registers.
  - The top level ANDs `count_en` into the 1 s tick. `clear` is ORed into the counter reset.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `BLINK_CYCLES`=4.

1. **Reset and debounced start.** Reset with keys released → `state`=IDLE, all outputs 0. Hold `key_n[0]`=0 for 20 cycles → `state`=RUN and `count_en`=1 exactly 8 (±1) cycles after the edge. Only one transition occurs.
2. **Bounce rejection.** `key_n[0]` toggles 0/1 every 2 cycles for 30 cycles, then stays at 1 → `state` stays IDLE and no event occurs.
3. **Pause/resume and clear.** Press start three times → RUN, PAUSE, RUN. Then press clear → `state`=IDLE, `clear` high for exactly 1 cycle, `count_en`=0.
4. **Time-up and alarm.**
   - In RUN, drive `timeup`=1 → DONE next cycle with `count_en`=0.
   - `alarm_led` pattern: 1,1,1,1,0,0,0,0,1…
   - Start press in DONE → IDLE with a one-cycle `clear` pulse and `alarm_led`=0.
5. **Simultaneous events.**
   - Start and clear released into the FSM in the same cycle from RUN → IDLE with `clear` pulsed.
   - `timeup` and a start press in the same cycle in RUN → DONE.
   - `timeup`=1 while in IDLE or PAUSE → no state change.
6. **Asynchronous reset mid-run.** Assert `rst_n`=0 mid-cycle while in RUN with the key held → all outputs return to reset values immediately. After release with the key still held, no spurious press occurs until the key is released and pressed again.
